btb_update_ctrl: RTL and testbench

- Sequences all writes into the 512-entry branch target buffer.
- Queues resolved-branch reports from EX and performs a read-modify-write of the indexed entry, applying a two-level (strong/weak) hysteresis policy.
- Runs a full invalidation sweep on request and, optionally, after reset.
- Sole owner of the BTB write port and of a second, update-side read port. The fetch-side lookup path is untouched.

---
 rtl/btb_update_ctrl_if.sv | 18 +
 rtl/btb_update_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_ctrl_if.sv
// Resolved-branch report handshake between EX (master) and btb_update_ctrl (slave).
interface btb_update_ctrl_if;
   logic        resolve_vld;
   logic        resolve_rdy;
   logic [15:0] resolve_PC;
   logic        resolve_taken;
   logic [15:0] resolve_target;

   modport master (
      output resolve_vld, resolve_PC, resolve_taken, resolve_target,
      input  resolve_rdy
   );

   modport slave (
      input  resolve_vld, resolve_PC, resolve_taken, resolve_target,
      output resolve_rdy
   );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: queued read-modify-write updates with strong/weak hysteresis and full sweeps.
// Optional update statistics outputs enabled by defining BTB_UPD_STATS_EN.
module btb_update_ctrl #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter bit          FLUSH_ON_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   btb_update_ctrl_if.slave    res,
   input  logic                flush_req,
   output logic                flush_done,
   output logic                busy,
   output logic [8:0]          rd_index,
   input  logic [25:0]         rd_data,
   output logic                wr_en,
   output logic [8:0]          wr_index,
   output logic [25:0]         wr_data
`ifdef BTB_UPD_STATS_EN
   ,
   output logic [15:0]         stat_alloc,
   output logic [15:0]         stat_replace,
   output logic [15:0]         stat_inval
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_EVAL  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]  state;
   logic [AW:0] wptr, rptr;
   logic [32:0] fifo_mem [FIFO_DEPTH];
   logic [32:0] head;
   logic        empty, full, rdy, push, flush_go;
   logic        flush_pend, live;
   logic [8:0]  sweep_cnt;
   logic [15:0] cur_pc, cur_tgt;
   logic        cur_taken;

   logic [6:0]  rd_tag, cur_tag;
   logic        rd_s, rd_v, hit;
   logic [15:0] rd_tgt;
   logic        eval_wr, alloc_ev, repl_ev, inval_ev;
   logic [25:0] eval_data;
   logic        unused_rsvd;

   assign head        = fifo_mem[rptr[AW-1:0]];
   assign empty       = (wptr == rptr);
   assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdy         = !full && (state != ST_FLUSH);
   assign res.resolve_rdy = rdy;
   assign push        = res.resolve_vld && rdy;
   assign flush_go    = (state == ST_IDLE) && (flush_pend || flush_req);
   assign busy        = (state != ST_IDLE) || !empty;
   assign rd_index    = empty ? '0 : head[25:17];

   assign rd_tag      = rd_data[24:18];
   assign rd_s        = rd_data[17];
   assign rd_v        = rd_data[16];
   assign rd_tgt      = rd_data[15:0];
   assign unused_rsvd = rd_data[25];
   assign cur_tag     = cur_pc[15:9];
   assign hit         = rd_v && (rd_tag == cur_tag);

   always_comb begin
      eval_wr   = 1'b0;
      eval_data = '0;
      alloc_ev  = 1'b0;
      repl_ev   = 1'b0;
      inval_ev  = 1'b0;
      if (hit) begin
         if (cur_taken) begin
            if (cur_tgt == rd_tgt) begin
               eval_wr   = !rd_s;
               eval_data = {1'b0, rd_tag, 1'b1, 1'b1, rd_tgt};
            end else if (rd_s) begin
               eval_wr   = 1'b1;
               eval_data = {1'b0, rd_tag, 1'b0, 1'b1, rd_tgt};
            end else begin
               eval_wr   = 1'b1;
               repl_ev   = 1'b1;
               eval_data = {1'b0, rd_tag, 1'b0, 1'b1, cur_tgt};
            end
         end else if (rd_s) begin
            eval_wr   = 1'b1;
            eval_data = {1'b0, rd_tag, 1'b0, 1'b1, rd_tgt};
         end else begin
            eval_wr   = 1'b1;
            inval_ev  = 1'b1;
            eval_data = {1'b0, rd_tag, 1'b0, 1'b0, rd_tgt};
         end
      end else if (cur_taken) begin
         // A strong incumbent only loses its S bit; it is replaced on the next miss.
         eval_wr = 1'b1;
         if (rd_v && rd_s) begin
            eval_data = {1'b0, rd_tag, 1'b0, 1'b1, rd_tgt};
         end else begin
            alloc_ev  = 1'b1;
            eval_data = {1'b0, cur_tag, 1'b0, 1'b1, cur_tgt};
         end
      end
   end

   // live holds off the first sweep write until one clock after reset release.
   assign wr_en    = ((state == ST_EVAL) && eval_wr) || ((state == ST_FLUSH) && live);
   assign wr_index = (state == ST_FLUSH) ? sweep_cnt : cur_pc[8:0];
   assign wr_data  = ((state == ST_EVAL) && eval_wr) ? eval_data : '0;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr[AW-1:0]] <= {res.resolve_PC, res.resolve_taken, res.resolve_target};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FLUSH_ON_RESET ? ST_FLUSH : ST_IDLE;
         wptr       <= '0;
         rptr       <= '0;
         sweep_cnt  <= '0;
         flush_pend <= 1'b0;
         flush_done <= 1'b0;
         live       <= 1'b0;
         cur_pc     <= '0;
         cur_tgt    <= '0;
         cur_taken  <= 1'b0;
      end else begin
         live       <= 1'b1;
         flush_done <= 1'b0;
         if (push) wptr <= wptr + PTR_ONE;
         if ((state != ST_FLUSH) && flush_req) flush_pend <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (flush_go) begin
                  state      <= ST_FLUSH;
                  sweep_cnt  <= '0;
                  flush_pend <= 1'b0;
                  wptr       <= '0;
                  rptr       <= '0;
               end else if (!empty) begin
                  cur_pc    <= head[32:17];
                  cur_taken <= head[16];
                  cur_tgt   <= head[15:0];
                  rptr      <= rptr + PTR_ONE;
                  state     <= ST_EVAL;
               end
            end
            ST_EVAL: state <= ST_IDLE;
            ST_FLUSH: begin
               if (live) begin
                  sweep_cnt <= sweep_cnt + 9'd1;
                  if (sweep_cnt == '1) begin
                     state      <= ST_IDLE;
                     flush_done <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef BTB_UPD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_alloc   <= '0;
         stat_replace <= '0;
         stat_inval   <= '0;
      end else if ((state == ST_FLUSH) && live && (sweep_cnt == '1)) begin
         stat_alloc   <= '0;
         stat_replace <= '0;
         stat_inval   <= '0;
      end else if (state == ST_EVAL) begin
         if (alloc_ev && (stat_alloc != '1))   stat_alloc   <= stat_alloc + 16'd1;
         if (repl_ev  && (stat_replace != '1)) stat_replace <= stat_replace + 16'd1;
         if (inval_ev && (stat_inval != '1))   stat_inval   <= stat_inval + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl with a behavioural 512-entry BTB (registered read).
module tb_btb_update_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_req, flush_done, busy, wr_en;
   logic [8:0]  rd_index, wr_index;
   logic [25:0] rd_data, wr_data;

   logic [25:0] btb [512];
   logic        pre_en;
   logic [8:0]  pre_idx;
   logic [25:0] pre_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   btb_update_ctrl_if rif ();

`ifdef BTB_UPD_STATS_EN
   logic [15:0] stat_alloc, stat_replace, stat_inval;
`endif

   btb_update_ctrl #(
      .FIFO_DEPTH    (4),
      .FLUSH_ON_RESET(1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .res       (rif),
      .flush_req (flush_req),
      .flush_done(flush_done),
      .busy      (busy),
      .rd_index  (rd_index),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_index  (wr_index),
      .wr_data   (wr_data)
`ifdef BTB_UPD_STATS_EN
      ,
      .stat_alloc  (stat_alloc),
      .stat_replace(stat_replace),
      .stat_inval  (stat_inval)
`endif
   );

   always @(posedge clk) begin
      if (pre_en)     btb[pre_idx]  <= pre_data;
      else if (wr_en) btb[wr_index] <= wr_data;
      rd_data <= btb[rd_index];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
      chk("push_rdy", 32'(rif.resolve_rdy), 32'd1);
      rif.resolve_vld    = 1'b1;
      rif.resolve_PC     = pc;
      rif.resolve_taken  = taken;
      rif.resolve_target = tgt;
      tick();
      rif.resolve_vld = 1'b0;
   endtask

   task automatic update(input string tag, input logic [15:0] pc, input logic taken,
                         input logic [15:0] tgt, input logic exp_wr, input logic [25:0] exp_data);
      push(pc, taken, tgt);
      chk({tag, "_rd_index"}, 32'(rd_index), 32'(pc[8:0]));
      tick();
      chk({tag, "_wr_en"}, 32'(wr_en), 32'(exp_wr));
      if (exp_wr) begin
         chk({tag, "_wr_index"}, 32'(wr_index), 32'(pc[8:0]));
         chk({tag, "_wr_data"}, 32'(wr_data), 32'(exp_data));
      end
      tick();
   endtask

   // Watches a sweep window; req_at re-issues flush_req mid-sweep (negative = never).
   task automatic sweep_watch(input string tag, input int cycles, input int req_at);
      int n_wr = 0, first = -1, last = -1, n_done = 0, done_at = -1;
      bit idx_bad = 0, data_bad = 0, rdy_seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         flush_req = (i == req_at);
         if (wr_en) begin
            if (first < 0) first = i;
            if (wr_index !== 9'(n_wr)) idx_bad = 1'b1;
            if (wr_data !== '0) data_bad = 1'b1;
            if (rif.resolve_rdy) rdy_seen = 1'b1;
            n_wr++;
            last = i;
         end
         if (flush_done) begin
            n_done++;
            done_at = i;
         end
      end
      flush_req = 1'b0;
      chk({tag, "_writes"}, 32'(n_wr), 32'd512);
      chk({tag, "_contig"}, 32'(last - first + 1), 32'd512);
      chk({tag, "_idx_seq"}, 32'(idx_bad), 32'd0);
      chk({tag, "_data_zero"}, 32'(data_bad), 32'd0);
      chk({tag, "_rdy_low"}, 32'(rdy_seen), 32'd0);
      chk({tag, "_done_cnt"}, 32'(n_done), 32'd1);
      chk({tag, "_done_at"}, 32'(done_at), 32'(last + 1));
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      flush_req = 1'b0;
      pre_en = 1'b0;
      pre_idx = '0;
      pre_data = '0;
      rif.resolve_vld = 1'b0;
      rif.resolve_PC = '0;
      rif.resolve_taken = 1'b0;
      rif.resolve_target = '0;
      repeat (3) tick();

      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_index", 32'(wr_index), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_rd_index", 32'(rd_index), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_rdy", 32'(rif.resolve_rdy), 32'd0);

      rst_n = 1'b1;
      sweep_watch("init_sweep", 560, -1);
      chk("init_idle_busy", 32'(busy), 32'd0);
      chk("init_idle_rdy", 32'(rif.resolve_rdy), 32'd1);

      update("alloc",       16'h0A05, 1'b1, 16'h1234, 1'b1, 26'h0151234);
      update("set_strong",  16'h0A05, 1'b1, 16'h1234, 1'b1, 26'h0171234);
      update("strong_nop",  16'h0A05, 1'b1, 16'h1234, 1'b0, 26'h0);
      update("nt_demote",   16'h0A05, 1'b0, 16'h0000, 1'b1, 26'h0151234);
      update("nt_inval",    16'h0A05, 1'b0, 16'h0000, 1'b1, 26'h0141234);
      update("realloc",     16'h0A05, 1'b1, 16'h1234, 1'b1, 26'h0151234);
      update("weak_retgt",  16'h0A05, 1'b1, 16'h5678, 1'b1, 26'h0155678);
      update("strengthen",  16'h0A05, 1'b1, 16'h5678, 1'b1, 26'h0175678);
      update("strong_keep", 16'h0A05, 1'b1, 16'h9999, 1'b1, 26'h0155678);

      pre_en = 1'b1;
      pre_idx = 9'h005;
      pre_data = 26'h1FFBEEF;
      tick();
      pre_en = 1'b0;
      update("miss_demote", 16'h0A05, 1'b1, 16'h1234, 1'b1, 26'h1FDBEEF);
      update("miss_alloc",  16'h0A05, 1'b1, 16'h1234, 1'b1, 26'h0151234);
      update("miss_nt",     16'h0A06, 1'b0, 16'h0000, 1'b0, 26'h0);

      k = 0;
      while (rif.resolve_rdy && k < 10) begin
         rif.resolve_vld    = 1'b1;
         rif.resolve_PC     = 16'h0010 + 16'(k);
         rif.resolve_taken  = 1'b1;
         rif.resolve_target = 16'h2000 + 16'(k);
         tick();
         k++;
      end
      rif.resolve_vld = 1'b0;
      chk("fill_pushes", 32'(k), 32'd7);
      chk("full_rdy", 32'(rif.resolve_rdy), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      tick();
      chk("mid_eval_wr_en", 32'(wr_en), 32'd1);
      chk("mid_eval_wr_index", 32'(wr_index), 32'h013);
      chk("mid_eval_wr_data", 32'(wr_data), 32'h0012003);
      flush_req = 1'b1;
      sweep_watch("req_sweep", 600, 20);
      chk("post_flush_busy", 32'(busy), 32'd0);
      chk("post_flush_rdy", 32'(rif.resolve_rdy), 32'd1);
      update("post_flush_miss", 16'h0A05, 1'b0, 16'h0000, 1'b0, 26'h0);

      push(16'h0A07, 1'b1, 16'h4444);
      rst_n = 1'b0;
      #1;
      chk("abort_wr_en", 32'(wr_en), 32'd0);
      chk("abort_rdy", 32'(rif.resolve_rdy), 32'd0);
      chk("abort_rd_index", 32'(rd_index), 32'd0);
      tick();
      rst_n = 1'b1;
      sweep_watch("abort_sweep", 560, -1);
      chk("abort_queue_lost", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
